// File: rtl/power_seq_pkg.sv
// Shared types and constants for the power sequencer and its sense conditioning.
package power_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_LOGIC_WAIT = 3'd1,
        ST_LOGIC_UP   = 3'd2,
        ST_PRECHARGE  = 3'd3,
        ST_MOTOR_WAIT = 3'd4,
        ST_ALL_UP     = 3'd5,
        ST_DISCHARGE  = 3'd6,
        ST_FAULT      = 3'd7
    } seq_state_e;

    localparam logic [2:0] FC_NONE          = 3'd0;
    localparam logic [2:0] FC_OVERCURRENT   = 3'd1;
    localparam logic [2:0] FC_OVERTEMP      = 3'd2;
    localparam logic [2:0] FC_ESTOP         = 3'd3;
    localparam logic [2:0] FC_LOGIC_TIMEOUT = 3'd4;
    localparam logic [2:0] FC_MOTOR_TIMEOUT = 3'd5;
    localparam logic [2:0] FC_PGOOD_LOST    = 3'd6;

    localparam int SNS_LOGIC_PGOOD    = 0;
    localparam int SNS_MOTOR_PGOOD    = 1;
    localparam int SNS_PRECHARGE_DONE = 2;
    localparam int SNS_OVERCURRENT    = 3;
    localparam int SNS_OVERTEMP       = 4;
    localparam int SNS_ESTOP          = 5;
    localparam int SNS_WIDTH          = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sense_debounce.sv
// One sense line: 2-flop synchroniser followed by a stability counter.
module sense_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic sense_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sense_q, sense_d;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; flip the output once the run is long enough.
    always_comb begin
        cnt_d   = cnt_q;
        sense_d = sense_q;
        if (sync2_q == sense_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            sense_d = ~sense_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and debounced output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            sense_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sense_q <= sense_d;
        end
    end

    assign sense_o = sense_q;

endmodule

// File: rtl/power_sequencer.sv
// Rail sequencer: logic rail -> precharge -> motor rail, with power-good checks,
// timeouts and a latched fault code.
//
// state          | meaning
// ---------------+------------------------------------------------------
// OFF            | all rails off, waiting for a logic request
// LOGIC_WAIT     | logic rail on, waiting for logic pgood
// LOGIC_UP       | logic rail up and good
// PRECHARGE      | precharge switch on, minimum dwell plus precharge done
// MOTOR_WAIT     | motor rail on, waiting for motor pgood
// ALL_UP         | both rails up, precharge switch off
// DISCHARGE      | motor rail off, fixed dwell before leaving
// FAULT          | everything off, fault code held until cleared
module power_sequencer
    import power_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000,
    parameter int STAGE_DELAY_CYCLES   = 500000,
    parameter int PGOOD_TIMEOUT_CYCLES = 5000000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] power_request_i,
    input  logic [5:0] power_sense_raw_i,
    input  logic       clear_fault_i,
    output logic [5:0] power_sense_o,
    output logic [1:0] rail_enable_o,
    output logic       precharge_enable_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o,
    output logic [2:0] seq_state_o
);

    localparam int TW = $clog2(max_int(STAGE_DELAY_CYCLES, PGOOD_TIMEOUT_CYCLES));
    localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(PGOOD_TIMEOUT_CYCLES - 1);

    logic [5:0]    sense;
    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    fault_code_q, fault_code_d;
    logic [2:0]    fault_sel;
    logic [1:0]    rail_q, rail_d;
    logic          pre_q, pre_d;
    logic          fault_q, fault_d;

    for (genvar i = 0; i < SNS_WIDTH; i++) begin : g_sense
        sense_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .raw_i   (power_sense_raw_i[i]),
            .sense_o (sense[i])
        );
    end

    // Fault detection, next-state decision and registered-output decode.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        fault_sel    = FC_NONE;

        if (state_q != ST_OFF && state_q != ST_FAULT) begin
            if (sense[SNS_ESTOP])
                fault_sel = FC_ESTOP;
            else if (sense[SNS_OVERCURRENT])
                fault_sel = FC_OVERCURRENT;
            else if (sense[SNS_OVERTEMP])
                fault_sel = FC_OVERTEMP;
            else if (state_q != ST_LOGIC_WAIT && !sense[SNS_LOGIC_PGOOD])
                fault_sel = FC_PGOOD_LOST;
            else if (state_q == ST_ALL_UP && !sense[SNS_MOTOR_PGOOD])
                fault_sel = FC_PGOOD_LOST;
        end

        if (fault_sel != FC_NONE) begin
            state_d      = ST_FAULT;
            fault_code_d = fault_sel;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // A held e-stop keeps us parked in OFF rather than faulting.
                    if (power_request_i[0] && !sense[SNS_ESTOP])
                        state_d = ST_LOGIC_WAIT;
                end
                ST_LOGIC_WAIT: begin
                    if (sense[SNS_LOGIC_PGOOD]) begin
                        state_d = ST_LOGIC_UP;
                    end else if (timer_q == TMO_LAST) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_LOGIC_TIMEOUT;
                    end else if (!power_request_i[0]) begin
                        state_d = ST_OFF;
                    end
                end
                ST_LOGIC_UP: begin
                    if (!power_request_i[0])
                        state_d = ST_OFF;
                    else if (power_request_i[1])
                        state_d = ST_PRECHARGE;
                end
                ST_PRECHARGE: begin
                    if (!sense[SNS_PRECHARGE_DONE] && timer_q == TMO_LAST) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_MOTOR_TIMEOUT;
                    end else if (!power_request_i[1]) begin
                        state_d = ST_DISCHARGE;
                    end else if (timer_q >= STAGE_LAST && sense[SNS_PRECHARGE_DONE]) begin
                        state_d = ST_MOTOR_WAIT;
                    end
                end
                ST_MOTOR_WAIT: begin
                    if (sense[SNS_MOTOR_PGOOD]) begin
                        state_d = ST_ALL_UP;
                    end else if (timer_q == TMO_LAST) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_MOTOR_TIMEOUT;
                    end else if (!power_request_i[1]) begin
                        state_d = ST_DISCHARGE;
                    end
                end
                ST_ALL_UP: begin
                    if (!power_request_i[1] || !power_request_i[0])
                        state_d = ST_DISCHARGE;
                end
                ST_DISCHARGE: begin
                    // Requests are only sampled once the dwell has elapsed.
                    if (timer_q == STAGE_LAST)
                        state_d = power_request_i[0] ? ST_LOGIC_UP : ST_OFF;
                end
                ST_FAULT: begin
                    if (clear_fault_i && power_request_i == 2'b00) begin
                        state_d      = ST_OFF;
                        fault_code_d = FC_NONE;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Timer restarts on every state entry and saturates otherwise.
        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + 1'b1;
        else
            timer_d = timer_q;

        rail_d  = 2'b00;
        pre_d   = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            ST_LOGIC_WAIT, ST_LOGIC_UP, ST_DISCHARGE: rail_d = 2'b01;
            ST_PRECHARGE: begin
                rail_d = 2'b01;
                pre_d  = 1'b1;
            end
            ST_MOTOR_WAIT: begin
                rail_d = 2'b11;
                pre_d  = 1'b1;
            end
            ST_ALL_UP: rail_d  = 2'b11;
            ST_FAULT:  fault_d = 1'b1;
            default:   rail_d  = 2'b00;
        endcase
    end

    // State, timer, fault code and output registers; reset drops every rail at once.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_OFF;
            timer_q      <= '0;
            fault_code_q <= FC_NONE;
            rail_q       <= 2'b00;
            pre_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fault_code_q <= fault_code_d;
            rail_q       <= rail_d;
            pre_q        <= pre_d;
            fault_q      <= fault_d;
        end
    end

    assign power_sense_o      = sense;
    assign rail_enable_o      = rail_q;
    assign precharge_enable_o = pre_q;
    assign fault_o            = fault_q;
    assign fault_code_o       = fault_code_q;
    assign seq_state_o        = state_q;

endmodule
